chunk_stream_arbiter: RTL and testbench

//  Shares one downstream chunk-serial big-number pipeline between two producers (A, B).

---
 rtl/chunk_stream_arbiter.sv | 150 +++++++++++++++
 tb/tb_chunk_stream_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_stream_arbiter.sv
// Round-robin arbiter that hands one chunk-serial big-number pipeline to producer A or B
// for a whole number at a time. Granted chunks are forwarded through one register stage.
module chunk_stream_arbiter #(
    parameter int BITS_IN_NUM   = 4096,
    parameter int REGISTER_SIZE = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     req_a_in,
    input  logic [REGISTER_SIZE-1:0] data_a_in,
    input  logic                     valid_a_in,
    input  logic                     req_b_in,
    input  logic [REGISTER_SIZE-1:0] data_b_in,
    input  logic                     valid_b_in,
    input  logic                     request_next_input,
    output logic                     grant_a_out,
    output logic                     grant_b_out,
    output logic [REGISTER_SIZE-1:0] data_out,
    output logic                     data_valid_out,
    output logic                     last_out,
    output logic                     src_b_out,
    output logic                     drop_err_out
);

    localparam int CHUNKS = BITS_IN_NUM / REGISTER_SIZE;
    localparam int CNT_W  = $clog2(CHUNKS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       last_served_b_q, last_served_b_d;
    logic                       grant_a_q, grant_a_d;
    logic                       grant_b_q, grant_b_d;
    logic [REGISTER_SIZE-1:0]   data_q, data_d;
    logic                       valid_q, valid_d;
    logic                       last_q, last_d;
    logic                       src_b_q, src_b_d;
    logic                       drop_err_q, drop_err_d;

    // Per-source views so the granted/other selection is a single index.
    logic                       src_valid [2];
    logic [REGISTER_SIZE-1:0]   src_data  [2];
    logic                       cur_is_b;
    logic                       fwd_valid;
    logic                       other_valid;
    logic [REGISTER_SIZE-1:0]   fwd_data;

    assign src_valid[0] = valid_a_in;
    assign src_valid[1] = valid_b_in;
    assign src_data[0]  = data_a_in;
    assign src_data[1]  = data_b_in;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        last_served_b_d = last_served_b_q;
        data_d          = data_q;
        valid_d         = 1'b0;
        last_d          = 1'b0;
        src_b_d         = src_b_q;
        drop_err_d      = drop_err_q;
        // Grants trail the state register by one cycle.
        grant_a_d       = (state_q == GRANT_A);
        grant_b_d       = (state_q == GRANT_B);
        cur_is_b        = (state_q == GRANT_B);
        fwd_valid       = src_valid[cur_is_b];
        other_valid     = src_valid[!cur_is_b];
        fwd_data        = src_data[cur_is_b];

        case (state_q)
            IDLE: begin
                if (valid_a_in || valid_b_in) begin
                    drop_err_d = 1'b1;
                end
                if (request_next_input) begin
                    if (req_a_in && req_b_in) begin
                        state_d = last_served_b_q ? GRANT_A : GRANT_B;
                    end else if (req_a_in) begin
                        state_d = GRANT_A;
                    end else if (req_b_in) begin
                        state_d = GRANT_B;
                    end
                end
            end
            GRANT_A, GRANT_B: begin
                if (other_valid) begin
                    drop_err_d = 1'b1;
                end
                if (fwd_valid) begin
                    data_d  = fwd_data;
                    valid_d = 1'b1;
                    src_b_d = cur_is_b;
                    last_d  = (cnt_q == LAST_IDX);
                    if (cnt_q == LAST_IDX) begin
                        cnt_d           = '0;
                        last_served_b_d = cur_is_b;
                        state_d         = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            last_served_b_q <= 1'b1;
            grant_a_q       <= 1'b0;
            grant_b_q       <= 1'b0;
            data_q          <= '0;
            valid_q         <= 1'b0;
            last_q          <= 1'b0;
            src_b_q         <= 1'b0;
            drop_err_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            last_served_b_q <= last_served_b_d;
            grant_a_q       <= grant_a_d;
            grant_b_q       <= grant_b_d;
            data_q          <= data_d;
            valid_q         <= valid_d;
            last_q          <= last_d;
            src_b_q         <= src_b_d;
            drop_err_q      <= drop_err_d;
        end
    end

    assign grant_a_out    = grant_a_q;
    assign grant_b_out    = grant_b_q;
    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign last_out       = last_q;
    assign src_b_out      = src_b_q;
    assign drop_err_out   = drop_err_q;

endmodule

// File: tb/tb_chunk_stream_arbiter.sv
// Directed bench for chunk_stream_arbiter with 128-bit numbers split into four 32-bit chunks.
module tb_chunk_stream_arbiter;

    localparam int RS = 32;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          req_a_in, req_b_in;
    logic [RS-1:0] data_a_in, data_b_in;
    logic          valid_a_in, valid_b_in;
    logic          request_next_input;
    logic          grant_a_out, grant_b_out;
    logic [RS-1:0] data_out;
    logic          data_valid_out, last_out, src_b_out, drop_err_out;

    int checks = 0;
    int errors = 0;

    chunk_stream_arbiter #(
        .BITS_IN_NUM   (128),
        .REGISTER_SIZE (RS)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .req_a_in           (req_a_in),
        .data_a_in          (data_a_in),
        .valid_a_in         (valid_a_in),
        .req_b_in           (req_b_in),
        .data_b_in          (data_b_in),
        .valid_b_in         (valid_b_in),
        .request_next_input (request_next_input),
        .grant_a_out        (grant_a_out),
        .grant_b_out        (grant_b_out),
        .data_out           (data_out),
        .data_valid_out     (data_valid_out),
        .last_out           (last_out),
        .src_b_out          (src_b_out),
        .drop_err_out       (drop_err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [RS-1:0] obs, input logic [RS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant_a"}, grant_a_out, 0);
        chk({tag, "_grant_b"}, grant_b_out, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_valid"}, data_valid_out, 0);
        chk({tag, "_last"}, last_out, 0);
        chk({tag, "_src"}, src_b_out, 0);
        chk({tag, "_drop"}, drop_err_out, 0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    // Bounded wait for any grant, then check which source received it.
    task automatic wait_grant(input bit exp_b, input string tag);
        int n = 0;
        step();
        while (!(grant_a_out || grant_b_out) && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, (n < 20), 1);
        chk({tag, "_grant_a"}, grant_a_out, !exp_b);
        chk({tag, "_grant_b"}, grant_b_out, exp_b);
    endtask

    task automatic drive(input bit is_b, input logic v, input logic [RS-1:0] d);
        if (is_b) begin
            valid_b_in = v;
            data_b_in  = d;
        end else begin
            valid_a_in = v;
            data_a_in  = d;
        end
    endtask

    // Chunk k carries base*(k+1); 'gap' idle cycles follow each non-final chunk.
    task automatic send_num(input bit is_b, input int gap, input logic [RS-1:0] base, input string tag);
        logic [RS-1:0] d;
        for (int k = 0; k < 4; k++) begin
            d = base * RS'(k + 1);
            drive(is_b, 1'b1, d);
            step();
            chk({tag, "_data"}, data_out, d);
            chk({tag, "_valid"}, data_valid_out, 1);
            chk({tag, "_last"}, last_out, (k == 3));
            chk({tag, "_src"}, src_b_out, is_b);
            drive(is_b, 1'b0, 0);
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk({tag, "_gap_valid"}, data_valid_out, 0);
                    chk({tag, "_gap_last"}, last_out, 0);
                    chk({tag, "_gap_hold"}, data_out, d);
                end
            end
        end
        step();
        chk({tag, "_end_grant_a"}, grant_a_out, 0);
        chk({tag, "_end_grant_b"}, grant_b_out, 0);
        chk({tag, "_end_valid"}, data_valid_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        req_a_in = 0; req_b_in = 0;
        valid_a_in = 0; valid_b_in = 0;
        data_a_in = 0; data_b_in = 0;
        request_next_input = 0;

        // Test 1: single A number, back-to-back chunks
        do_reset();
        chk_reset("t1_reset");
        req_a_in = 1;
        request_next_input = 1;
        step();
        step();
        chk("t1_grant_a", grant_a_out, 1);
        chk("t1_grant_b", grant_b_out, 0);
        req_a_in = 0;
        send_num(0, 0, 32'h11, "t1");

        // Test 2: both requesting from reset, alternation starting with A
        do_reset();
        req_a_in = 1;
        req_b_in = 1;
        wait_grant(0, "t2_n0");
        send_num(0, 0, 32'h100, "t2_n0");
        wait_grant(1, "t2_n1");
        send_num(1, 0, 32'h200, "t2_n1");
        wait_grant(0, "t2_n2");
        send_num(0, 0, 32'h300, "t2_n2");
        wait_grant(1, "t2_n3");
        req_a_in = 0;
        req_b_in = 0;
        send_num(1, 0, 32'h400, "t2_n3");

        // Test 3: A with two-cycle gaps between chunks
        do_reset();
        req_a_in = 1;
        wait_grant(0, "t3");
        req_a_in = 0;
        send_num(0, 2, 32'h1000, "t3");
        chk("t3_drop", drop_err_out, 0);

        // Test 5: downstream not ready holds off the grant
        request_next_input = 0;
        req_b_in = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_no_grant", grant_b_out, 0);
        end
        request_next_input = 1;
        step();
        step();
        chk("t5_grant_b", grant_b_out, 1);
        req_b_in = 0;
        send_num(1, 0, 32'h7, "t5");

        // Test 4: stray B chunk while A granted
        req_a_in = 1;
        wait_grant(0, "t4");
        req_a_in = 0;
        drive(0, 1, 32'hA1);
        step();
        chk("t4_c0", data_out, 32'hA1);
        chk("t4_drop0", drop_err_out, 0);
        drive(0, 1, 32'hA2);
        drive(1, 1, 32'hBB);
        step();
        chk("t4_c1", data_out, 32'hA2);
        chk("t4_c1_src", src_b_out, 0);
        chk("t4_drop1", drop_err_out, 1);
        drive(1, 0, 0);
        drive(0, 1, 32'hA3);
        step();
        chk("t4_c2", data_out, 32'hA3);
        drive(0, 1, 32'hA4);
        step();
        chk("t4_c3", data_out, 32'hA4);
        chk("t4_c3_last", last_out, 1);
        drive(0, 0, 0);
        step();
        chk("t4_end_grant", grant_a_out, 0);
        chk("t4_drop_sticky", drop_err_out, 1);

        // Test 6: reset in the middle of an A number
        req_a_in = 1;
        wait_grant(0, "t6");
        req_a_in = 0;
        drive(0, 1, 32'hC1);
        step();
        chk("t6_c0", data_out, 32'hC1);
        drive(0, 1, 32'hC2);
        step();
        chk("t6_c1", data_out, 32'hC2);
        chk("t6_c1_last", last_out, 0);
        chk("t6_drop_pre", drop_err_out, 1);
        drive(0, 0, 0);
        rst_in = 1;
        step();
        rst_in = 0;
        chk_reset("t6_reset");
        req_a_in = 1;
        wait_grant(0, "t6_re");
        req_a_in = 0;
        send_num(0, 0, 32'hD, "t6_re");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
